// File: rtl/nexys_starship_lane_ctrl.sv
// nexys_starship_lane_ctrl
//   Four-lane monster controller for the starship game. Random spawn flags
//   and a random hex value from the PRNG become monsters on the top, bottom,
//   left and right lanes. A monster travels for TRAVEL_CYCLES cycles. A shot
//   with the matching code destroys it; a monster that is not shot arrives
//   and costs a life. Each lane then cools down for COOLDOWN_CYCLES cycles.
//   A game-level FSM tracks score, lives and game over.
//
// Ports (lane index: 0 = top, 1 = btm, 2 = left, 3 = right)
//   Clk           in   system clock, rising edge
//   Reset_n       in   asynchronous active-low reset
//   start         in   single-cycle start pulse
//   *_random      in   per-lane spawn flags
//   random_hex    in   [3:0]  PRNG hex value
//   shoot         in   [3:0]  single-cycle shot pulse per lane
//   sw_code       in   [3:0]  player code from the switches
//   lane_active   out  [3:0]  a monster is present on the lane
//   lane_code     out  [15:0] code of lane i in bits [4i+3:4i]
//   lane_urgent   out  [3:0]  active with less than a quarter of travel left
//   score         out  [7:0]  kill count, saturating at 255
//   lives         out  [1:0]  remaining lives
//   kill_pulse    out  one cycle after an edge with at least one kill
//   damage_pulse  out  one cycle after an edge with at least one arrival
//   playing       out  game in progress
//   game_over     out  game finished, waiting for start
module nexys_starship_lane_ctrl #(
  parameter int TIMER_W         = 27,
  parameter int TRAVEL_CYCLES   = 100_000_000,
  parameter int COOLDOWN_CYCLES = 50_000_000,
  parameter int SPAWN_DIV       = 25_000_000,
  parameter int LIVES           = 3
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        start,
  input  logic        top_random,
  input  logic        btm_random,
  input  logic        left_random,
  input  logic        right_random,
  input  logic [3:0]  random_hex,
  input  logic [3:0]  shoot,
  input  logic [3:0]  sw_code,
  output logic [3:0]  lane_active,
  output logic [15:0] lane_code,
  output logic [3:0]  lane_urgent,
  output logic [7:0]  score,
  output logic [1:0]  lives,
  output logic        kill_pulse,
  output logic        damage_pulse,
  output logic        playing,
  output logic        game_over
);

  typedef enum logic [1:0] {
    G_IDLE = 2'd0,
    G_PLAY = 2'd1,
    G_OVER = 2'd2
  } game_state_e;

  typedef enum logic [1:0] {
    L_IDLE   = 2'd0,
    L_ACTIVE = 2'd1,
    L_COOL   = 2'd2
  } lane_state_e;

  localparam logic [TIMER_W-1:0] T_ZERO      = {TIMER_W{1'b0}};
  localparam logic [TIMER_W-1:0] T_ONE       = {{(TIMER_W-1){1'b0}}, 1'b1};
  localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);
  localparam logic [TIMER_W-1:0] COOL_LOAD   = TIMER_W'(COOLDOWN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DIV_LAST    = TIMER_W'(SPAWN_DIV - 1);
  localparam logic [TIMER_W-1:0] URGENT_LIM  = TIMER_W'(TRAVEL_CYCLES / 4);
  localparam logic [1:0]         LIVES_LOAD  = 2'(LIVES);

  // Number of set bits in a 4-bit lane vector.
  function automatic logic [2:0] count_ones4(input logic [3:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int k = 0; k < 4; k++) begin
      n = n + {2'b00, v[k]};
    end
    return n;
  endfunction

  game_state_e        g_state_r;
  game_state_e        g_state_nxt_s;
  logic               game_init_s;
  logic               lanes_freeze_s;
  logic               playing_nxt_s;
  logic               game_over_nxt_s;

  logic [TIMER_W-1:0] div_r;
  logic [TIMER_W-1:0] div_nxt_s;
  logic               spawn_tick_s;
  logic [3:0]         spawn_flag_s;

  lane_state_e        lane_state_r      [4];
  lane_state_e        lane_cand_state_s [4];
  lane_state_e        lane_state_nxt_s  [4];
  logic [TIMER_W-1:0] lane_timer_r      [4];
  logic [TIMER_W-1:0] lane_cand_timer_s [4];
  logic [TIMER_W-1:0] lane_timer_nxt_s  [4];
  logic [15:0]        lane_code_nxt_s;
  logic [3:0]         active_nxt_s;
  logic [3:0]         urgent_nxt_s;

  logic [3:0]         kill_s;
  logic [3:0]         arrive_s;
  logic [2:0]         kill_cnt_s;
  logic [2:0]         arrive_cnt_s;
  logic [8:0]         score_sum_s;
  logic [7:0]         score_play_s;
  logic [7:0]         score_nxt_s;
  logic [1:0]         lives_play_s;
  logic [1:0]         lives_nxt_s;

  assign spawn_flag_s = {right_random, left_random, btm_random, top_random};
  assign spawn_tick_s = (g_state_r == G_PLAY) && (div_r == DIV_LAST);

  // Per-lane lifecycle ignoring game-level overrides; yields kills and arrivals.
  always_comb begin
    lane_code_nxt_s = lane_code;
    kill_s          = 4'b0000;
    arrive_s        = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      lane_cand_state_s[i] = lane_state_r[i];
      lane_cand_timer_s[i] = lane_timer_r[i];
      case (lane_state_r[i])
        L_IDLE: begin
          if (spawn_tick_s && spawn_flag_s[i]) begin
            lane_cand_state_s[i]       = L_ACTIVE;
            lane_cand_timer_s[i]       = TRAVEL_LOAD;
            lane_code_nxt_s[4*i +: 4]  = random_hex ^ 4'(i);
          end else begin
            lane_cand_state_s[i] = L_IDLE;
          end
        end
        L_ACTIVE: begin
          // A matching shot takes priority over an arrival on the same edge.
          if (shoot[i] && (sw_code == lane_code[4*i +: 4])) begin
            kill_s[i]            = 1'b1;
            lane_cand_state_s[i] = L_COOL;
            lane_cand_timer_s[i] = COOL_LOAD;
          end else if (lane_timer_r[i] == T_ZERO) begin
            arrive_s[i]          = 1'b1;
            lane_cand_state_s[i] = L_COOL;
            lane_cand_timer_s[i] = COOL_LOAD;
          end else begin
            lane_cand_timer_s[i] = lane_timer_r[i] - T_ONE;
          end
        end
        L_COOL: begin
          if (lane_timer_r[i] == T_ZERO) begin
            lane_cand_state_s[i] = L_IDLE;
          end else begin
            lane_cand_timer_s[i] = lane_timer_r[i] - T_ONE;
          end
        end
        default: begin
          lane_cand_state_s[i] = L_IDLE;
          lane_cand_timer_s[i] = T_ZERO;
        end
      endcase
    end
  end

  // Saturating score and lives updates from this edge's kills and arrivals.
  always_comb begin
    kill_cnt_s   = count_ones4(kill_s);
    arrive_cnt_s = count_ones4(arrive_s);
    score_sum_s  = {1'b0, score} + {6'd0, kill_cnt_s};
    if (score_sum_s > 9'd255) begin
      score_play_s = 8'd255;
    end else begin
      score_play_s = score_sum_s[7:0];
    end
    // arrive_cnt_s is below lives here, so its low two bits are exact.
    if ({1'b0, lives} > arrive_cnt_s) begin
      lives_play_s = lives - arrive_cnt_s[1:0];
    end else begin
      lives_play_s = 2'd0;
    end
  end

  // Game FSM state register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      g_state_r <= G_IDLE;
    end else begin
      g_state_r <= g_state_nxt_s;
    end
  end

  // Game FSM next-state logic; game over looks at the lives value being written.
  always_comb begin
    g_state_nxt_s = g_state_r;
    case (g_state_r)
      G_IDLE, G_OVER: begin
        if (start) begin
          g_state_nxt_s = G_PLAY;
        end else begin
          g_state_nxt_s = g_state_r;
        end
      end
      G_PLAY: begin
        if (lives_play_s == 2'd0) begin
          g_state_nxt_s = G_OVER;
        end else begin
          g_state_nxt_s = G_PLAY;
        end
      end
      default: begin
        g_state_nxt_s = G_IDLE;
      end
    endcase
  end

  // Game FSM outputs: (re)initialisation, lane freeze and next score/lives.
  always_comb begin
    game_init_s     = (g_state_r != G_PLAY) && (g_state_nxt_s == G_PLAY);
    lanes_freeze_s  = (g_state_nxt_s != G_PLAY) || game_init_s;
    playing_nxt_s   = (g_state_nxt_s == G_PLAY);
    game_over_nxt_s = (g_state_nxt_s == G_OVER);
    if (game_init_s) begin
      score_nxt_s = 8'd0;
      lives_nxt_s = LIVES_LOAD;
    end else if (g_state_r == G_PLAY) begin
      score_nxt_s = score_play_s;
      lives_nxt_s = lives_play_s;
    end else begin
      score_nxt_s = score;
      lives_nxt_s = lives;
    end
  end

  // Spawn divider runs only while the game stays in play; cleared otherwise.
  always_comb begin
    if ((g_state_r == G_PLAY) && (g_state_nxt_s == G_PLAY)) begin
      if (div_r == DIV_LAST) begin
        div_nxt_s = T_ZERO;
      end else begin
        div_nxt_s = div_r + T_ONE;
      end
    end else begin
      div_nxt_s = T_ZERO;
    end
  end

  // Final lane next state: game start or game over forces every lane idle.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if (lanes_freeze_s) begin
        lane_state_nxt_s[i] = L_IDLE;
        lane_timer_nxt_s[i] = T_ZERO;
      end else begin
        lane_state_nxt_s[i] = lane_cand_state_s[i];
        lane_timer_nxt_s[i] = lane_cand_timer_s[i];
      end
      active_nxt_s[i] = (lane_state_nxt_s[i] == L_ACTIVE);
      urgent_nxt_s[i] = active_nxt_s[i] && (lane_timer_nxt_s[i] < URGENT_LIM);
    end
  end

  // Lane state and timer registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 4; i++) begin
        lane_state_r[i] <= L_IDLE;
        lane_timer_r[i] <= T_ZERO;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        lane_state_r[i] <= lane_state_nxt_s[i];
        lane_timer_r[i] <= lane_timer_nxt_s[i];
      end
    end
  end

  // Divider and registered outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_r        <= T_ZERO;
      lane_active  <= 4'b0000;
      lane_code    <= 16'h0000;
      lane_urgent  <= 4'b0000;
      score        <= 8'd0;
      lives        <= 2'd0;
      kill_pulse   <= 1'b0;
      damage_pulse <= 1'b0;
      playing      <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      div_r        <= div_nxt_s;
      lane_active  <= active_nxt_s;
      lane_code    <= lane_code_nxt_s;
      lane_urgent  <= urgent_nxt_s;
      score        <= score_nxt_s;
      lives        <= lives_nxt_s;
      kill_pulse   <= (g_state_r == G_PLAY) && (|kill_s);
      damage_pulse <= (g_state_r == G_PLAY) && (|arrive_s);
      playing      <= playing_nxt_s;
      game_over    <= game_over_nxt_s;
    end
  end

endmodule

// File: tb/tb_nexys_starship_lane_ctrl.sv
// tb_nexys_starship_lane_ctrl
//   Directed scenarios followed by a randomized phase. Expected outputs come
//   from a reference model that tracks each monster by absolute deadlines
//   (arrival edge, end-of-cooldown edge) and spawn ticks by edge arithmetic
//   relative to the edge that started the game.
module tb_nexys_starship_lane_ctrl;

  localparam int TRAVEL = 8;
  localparam int COOL   = 4;
  localparam int SDIV   = 4;
  localparam int NLIVES = 3;

  logic        Clk;
  logic        Reset_n;
  logic        start;
  logic        top_random, btm_random, left_random, right_random;
  logic [3:0]  random_hex;
  logic [3:0]  shoot;
  logic [3:0]  sw_code;
  logic [3:0]  lane_active;
  logic [15:0] lane_code;
  logic [3:0]  lane_urgent;
  logic [7:0]  score;
  logic [1:0]  lives;
  logic        kill_pulse;
  logic        damage_pulse;
  logic        playing;
  logic        game_over;

  nexys_starship_lane_ctrl #(
    .TIMER_W        (27),
    .TRAVEL_CYCLES  (TRAVEL),
    .COOLDOWN_CYCLES(COOL),
    .SPAWN_DIV      (SDIV),
    .LIVES          (NLIVES)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .start       (start),
    .top_random  (top_random),
    .btm_random  (btm_random),
    .left_random (left_random),
    .right_random(right_random),
    .random_hex  (random_hex),
    .shoot       (shoot),
    .sw_code     (sw_code),
    .lane_active (lane_active),
    .lane_code   (lane_code),
    .lane_urgent (lane_urgent),
    .score       (score),
    .lives       (lives),
    .kill_pulse  (kill_pulse),
    .damage_pulse(damage_pulse),
    .playing     (playing),
    .game_over   (game_over)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time budget exceeded");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;

  // Reference model: game 0 idle, 1 play, 2 over; lane 0 idle, 1 active, 2 cool.
  int         cyc = 0;
  int         t0  = 0;
  int         m_g;
  int         m_phase   [4];
  int         m_act_end [4];
  int         m_cool_end[4];
  logic [3:0] m_code    [4];
  int         m_score;
  int         m_lives;
  bit         m_kp, m_dp;

  task automatic model_reset();
    m_g = 0;
    for (int i = 0; i < 4; i++) begin
      m_phase[i]    = 0;
      m_act_end[i]  = 0;
      m_cool_end[i] = 0;
      m_code[i]     = 4'h0;
    end
    m_score = 0;
    m_lives = 0;
    m_kp    = 1'b0;
    m_dp    = 1'b0;
  endtask

  task automatic model_edge();
    int       k, a;
    bit       tick;
    bit [3:0] flags;
    cyc++;
    k = 0;
    a = 0;
    flags = {right_random, left_random, btm_random, top_random};
    if (m_g == 1) begin
      tick = (cyc > t0) && (((cyc - t0) % SDIV) == 0);
      for (int i = 0; i < 4; i++) begin
        if (m_phase[i] == 1) begin
          if (shoot[i] && (sw_code == m_code[i])) begin
            k++;
            m_phase[i]    = 2;
            m_cool_end[i] = cyc + COOL;
          end else if (cyc == m_act_end[i]) begin
            a++;
            m_phase[i]    = 2;
            m_cool_end[i] = cyc + COOL;
          end
        end else if (m_phase[i] == 2) begin
          if (cyc == m_cool_end[i]) m_phase[i] = 0;
        end else if (tick && flags[i]) begin
          m_phase[i]   = 1;
          m_code[i]    = random_hex ^ 4'(i);
          m_act_end[i] = cyc + TRAVEL;
        end
      end
      m_score = (m_score + k > 255) ? 255 : m_score + k;
      m_lives = (m_lives > a) ? m_lives - a : 0;
      m_kp = (k > 0);
      m_dp = (a > 0);
      if (m_lives == 0) begin
        m_g = 2;
        for (int i = 0; i < 4; i++) m_phase[i] = 0;
      end
    end else begin
      m_kp = 1'b0;
      m_dp = 1'b0;
      if (start) begin
        m_g     = 1;
        t0      = cyc;
        m_lives = NLIVES;
        m_score = 0;
        for (int i = 0; i < 4; i++) m_phase[i] = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [3:0]  ea, eu;
    logic [15:0] ec;
    for (int i = 0; i < 4; i++) begin
      ea[i] = (m_phase[i] == 1);
      eu[i] = ea[i] && ((m_act_end[i] - cyc - 1) < (TRAVEL / 4));
      ec[4*i +: 4] = m_code[i];
    end
    chk("lane_active", 32'(lane_active), 32'(ea));
    chk("lane_code", 32'(lane_code), 32'(ec));
    chk("lane_urgent", 32'(lane_urgent), 32'(eu));
    chk("score", 32'(score), 32'(m_score));
    chk("lives", 32'(lives), 32'(m_lives));
    chk("kill_pulse", 32'(kill_pulse), 32'(m_kp));
    chk("damage_pulse", 32'(damage_pulse), 32'(m_dp));
    chk("playing", 32'(playing), 32'(m_g == 1));
    chk("game_over", 32'(game_over), 32'(m_g == 2));
  endtask

  task automatic step();
    model_edge();
    @(posedge Clk);
    #1;
    check_all();
  endtask

  task automatic set_flags(input logic [3:0] f);
    {right_random, left_random, btm_random, top_random} = f;
  endtask

  task automatic wait_active(input int lane, input int budget);
    int n;
    n = 0;
    while ((m_phase[lane] != 1) && (n < budget)) begin
      step();
      n++;
    end
    chk("wait_active", 32'(lane_active[lane]), 32'd1);
  endtask

  initial begin
    int n;
    int pick;
    Reset_n    = 1'b0;
    start      = 1'b0;
    set_flags(4'b0000);
    random_hex = 4'h0;
    shoot      = 4'b0000;
    sw_code    = 4'h0;
    model_reset();
    #12;
    check_all();
    Reset_n = 1'b1;
    step();

    // 1: top lane spawn and unshot arrival
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_playing", 32'(playing), 32'd1);
    set_flags(4'b0001);
    random_hex = 4'h6;
    for (int i = 0; i < 4; i++) step();
    chk("t1_spawn_active", 32'(lane_active[0]), 32'd1);
    chk("t1_spawn_code", 32'(lane_code[3:0]), 32'h6);
    chk("t1_spawn_lives", 32'(lives), 32'd3);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("t1_travel", 32'(lane_active[0]), 32'd1);
    end
    step();
    chk("t1_arrive_active", 32'(lane_active[0]), 32'd0);
    chk("t1_arrive_damage", 32'(damage_pulse), 32'd1);
    chk("t1_arrive_lives", 32'(lives), 32'd2);
    set_flags(4'b0000);
    step();
    chk("t1_damage_single", 32'(damage_pulse), 32'd0);

    // 2: left lane, wrong code then right code
    set_flags(4'b0100);
    random_hex = 4'h5;
    wait_active(2, 12);
    set_flags(4'b0000);
    chk("t2_code", 32'(lane_code[11:8]), 32'h7);
    shoot = 4'b0100; sw_code = 4'h3;
    step();
    shoot = 4'b0000;
    chk("t2_wrong_active", 32'(lane_active[2]), 32'd1);
    chk("t2_wrong_score", 32'(score), 32'd0);
    shoot = 4'b0100; sw_code = 4'h7;
    step();
    shoot = 4'b0000;
    chk("t2_kill_active", 32'(lane_active[2]), 32'd0);
    chk("t2_kill_pulse", 32'(kill_pulse), 32'd1);
    chk("t2_kill_score", 32'(score), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_cool_idle", 32'(lane_active[2]), 32'd0);
    end

    // 3: valid shot on the arrival edge counts as a kill
    set_flags(4'b0010);
    random_hex = 4'h3;
    wait_active(1, 12);
    set_flags(4'b0000);
    n = 0;
    while ((m_act_end[1] != cyc + 1) && (n < 10)) begin
      step();
      n++;
    end
    shoot = 4'b0010; sw_code = 4'h2;
    step();
    shoot = 4'b0000;
    chk("t3_score", 32'(score), 32'd2);
    chk("t3_lives", 32'(lives), 32'd2);
    chk("t3_kill", 32'(kill_pulse), 32'd1);
    chk("t3_no_damage", 32'(damage_pulse), 32'd0);

    // 6: asynchronous reset mid-game with lanes active
    set_flags(4'b1111);
    random_hex = 4'($urandom_range(0, 15));
    wait_active(3, 12);
    set_flags(4'b0000);
    #2;
    Reset_n = 1'b0;
    #1;
    model_reset();
    chk("t6_active", 32'(lane_active), 32'd0);
    chk("t6_code", 32'(lane_code), 32'd0);
    chk("t6_playing", 32'(playing), 32'd0);
    chk("t6_lives", 32'(lives), 32'd0);
    check_all();
    Reset_n = 1'b1;
    step();

    // 4: four simultaneous arrivals end the game
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t4_lives_load", 32'(lives), 32'd3);
    set_flags(4'b1111);
    random_hex = 4'($urandom_range(0, 15));
    wait_active(0, 12);
    set_flags(4'b0000);
    chk("t4_all_active", 32'(lane_active), 32'hF);
    n = 0;
    while ((m_phase[0] == 1) && (n < 12)) begin
      step();
      n++;
    end
    chk("t4_damage", 32'(damage_pulse), 32'd1);
    chk("t4_lives", 32'(lives), 32'd0);
    chk("t4_game_over", 32'(game_over), 32'd1);
    chk("t4_playing", 32'(playing), 32'd0);
    chk("t4_active", 32'(lane_active), 32'd0);
    step();
    chk("t4_damage_single", 32'(damage_pulse), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t4_restart_playing", 32'(playing), 32'd1);
    chk("t4_restart_lives", 32'(lives), 32'd3);
    chk("t4_restart_score", 32'(score), 32'd0);
    chk("t4_restart_over", 32'(game_over), 32'd0);

    // 5: build score to 254, then a double kill and one more kill saturate
    set_flags(4'b0001);
    n = 0;
    while ((m_score < 254) && (n < 4000)) begin
      random_hex = 4'($urandom_range(0, 15));
      if (m_phase[0] == 1) begin
        shoot = 4'b0001; sw_code = m_code[0];
      end else begin
        shoot = 4'b0000; sw_code = 4'($urandom_range(0, 15));
      end
      step();
      n++;
    end
    shoot = 4'b0000;
    set_flags(4'b0000);
    chk("t5_preload", 32'(score), 32'd254);
    for (int i = 0; i < 10; i++) step();
    random_hex = 4'h6;
    set_flags(4'b0001);
    wait_active(0, 12);
    set_flags(4'b0100);
    random_hex = 4'h4;
    wait_active(2, 12);
    set_flags(4'b0000);
    chk("t5_pair_codes", 32'({lane_code[11:8], lane_code[3:0]}), 32'h66);
    shoot = 4'b0101; sw_code = 4'h6;
    step();
    shoot = 4'b0000;
    chk("t5_double_score", 32'(score), 32'd255);
    chk("t5_double_pulse", 32'(kill_pulse), 32'd1);
    random_hex = 4'($urandom_range(0, 15));
    set_flags(4'b0001);
    wait_active(0, 20);
    set_flags(4'b0000);
    shoot = 4'b0001; sw_code = m_code[0];
    step();
    shoot = 4'b0000;
    chk("t5_sat_score", 32'(score), 32'd255);
    chk("t5_sat_pulse", 32'(kill_pulse), 32'd1);

    // Randomized phase
    for (int r = 0; r < 800; r++) begin
      set_flags(4'($urandom_range(0, 15)));
      random_hex = 4'($urandom_range(0, 15));
      start = ($urandom_range(0, 29) == 0);
      shoot = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      pick = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) sw_code = m_code[pick];
      else sw_code = 4'($urandom_range(0, 15));
      step();
    end
    start = 1'b0;
    shoot = 4'b0000;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nexys_starship_lane_ctrl.md
# nexys_starship_lane_ctrl

Consumer of the starship PRNG outputs: turns per-direction random spawn flags and the random hex value into live monsters on four lanes (top, bottom, left, right). Each lane runs a monster lifecycle with a travel timer. A monster is destroyed by a matching-code shot; an unshot monster that arrives costs a life. A game-level FSM tracks score, lives and game over, and drives the display and scoring logic downstream.

## Interface
Parameters:
- TIMER_W, 27, width of the lane travel/cooldown timers and the spawn divider.
- TRAVEL_CYCLES, 100_000_000, cycles a monster stays active before arrival (must be ≥ 2).
- COOLDOWN_CYCLES, 50_000_000, cycles a lane is blocked after a kill or arrival (must be ≥ 1).
- SPAWN_DIV, 25_000_000, period in cycles between spawn evaluations (must be ≥ 2).
- LIVES, 3, lives loaded at game start (1–3).

Ports (lane index: 0 = top, 1 = btm, 2 = left, 3 = right):
- Clk, input, 1, system clock; all logic on its rising edge.
- Reset_n, input, 1, asynchronous, active-low reset.
- start, input, 1, single-cycle debounced start pulse.
- top_random, btm_random, left_random, right_random, input, 1 each, PRNG spawn flags. Same clock domain; sampled directly.
- random_hex, input, 4, PRNG hex value.
- shoot, input, 4, single-cycle debounced shot pulse per lane.
- sw_code, input, 4, player code from switches.
- lane_active, output, 4, monster present on the lane.
- lane_code, output, 16, 4-bit code of each lane; lane i occupies bits [4i+3:4i].
- lane_urgent, output, 4, active monster with remaining timer < TRAVEL_CYCLES/4.
- score, output, 8, kill count, saturating at 255.
- lives, output, 2, remaining lives.
- kill_pulse, output, 1, one cycle per edge on which ≥ 1 kill occurred.
- damage_pulse, output, 1, one cycle per edge on which ≥ 1 arrival occurred.
- playing, output, 1, game FSM in G_PLAY.
- game_over, output, 1, game FSM in G_OVER.

## Operation
Game FSM:
- G_IDLE → G_PLAY on start. Entering G_PLAY loads lives = LIVES, clears score, forces every lane to L_IDLE, and clears the spawn divider.
- G_PLAY → G_OVER when lives reaches 0. Lanes freeze to L_IDLE. score holds its value.
- G_OVER → G_PLAY on start, with the same reinitialisation as above.
- start is ignored while in G_PLAY.

Spawn divider:
- Counts 0 … SPAWN_DIV−1 in G_PLAY only, then wraps.
- spawn_tick is asserted when the count equals SPAWN_DIV−1.

Lane FSM (identical per lane):
- L_IDLE → L_ACTIVE on spawn_tick when that lane's random flag is 1.
  - Latches code = random_hex XOR lane index.
  - Loads timer = TRAVEL_CYCLES−1.
  - Several lanes may spawn on the same tick.
- L_ACTIVE, valid shot (shoot[i] = 1 and sw_code == code) → L_COOL.
  - Counts as a kill; timer = COOLDOWN_CYCLES−1.
- L_ACTIVE, otherwise, timer == 0 → L_COOL.
  - Counts as an arrival; timer = COOLDOWN_CYCLES−1.
- L_ACTIVE, otherwise → timer decrements by 1.
- L_ACTIVE, shot with a wrong code → no effect.
- L_COOL → L_IDLE when timer == 0; otherwise timer decrements. Shots are ignored in L_COOL.
- Shots on an idle lane are ignored.

Arithmetic:
- A valid shot and timer == 0 on the same edge count as a kill (the shot wins).
- score += number of kills on the edge, saturating at 255.
- lives −= number of arrivals on the edge, saturating at 0.
- Kills and arrivals on the same edge are both applied.

## Timing
- Reset values: all lanes L_IDLE, timers 0, game FSM G_IDLE.
  - lane_active = 0, lane_code = 0, lane_urgent = 0.
  - score = 0, lives = 0, kill_pulse = 0, damage_pulse = 0.
  - playing = 0, game_over = 0.
- All outputs are registered.
- State change latency: lane_active rises on the edge that samples spawn_tick with the flag high. It falls on the edge that samples the valid shot or timer == 0.
- Active duration: an unshot monster is active for exactly TRAVEL_CYCLES cycles.
- Cooldown duration: L_COOL lasts COOLDOWN_CYCLES cycles.
- Pulse alignment: kill_pulse and damage_pulse are asserted for the single cycle following the causing edge, aligned with the score/lives update.
- playing updates one edge after start. game_over updates on the edge where lives becomes 0.
- Reset_n low mid-game: immediate return to reset values, independent of Clk.

## Test plan
Bench parameters: TRAVEL_CYCLES=8, COOLDOWN_CYCLES=4, SPAWN_DIV=4, LIVES=3.

1. Reset, then start; hold top_random=1, random_hex=4'h6.
   - At the first spawn_tick: lane_active[0]=1, lane_code[3:0]=4'h6, lives=3.
   - After 8 cycles: lane_active[0]=0, damage_pulse for 1 cycle, lives=2.
2. Spawn on left (index 2) with random_hex=4'h5, so code=4'h7.
   - shoot[2] with sw_code=4'h3 → no change.
   - shoot[2] with sw_code=4'h7 → lane_active[2]=0 next cycle, kill_pulse=1, score=1.
   - Lane then stays idle for 4 cycles.
3. Valid shot on the same edge as timer == 0 → kill (score+1); no damage, lives unchanged.
4. Four lanes spawn together and all arrive with lives=3.
   - One damage_pulse; lives=0; game_over=1; lane_active=0.
   - A subsequent start → playing=1, lives=3, score=0.
5. Preload score=254; two valid shots on the same edge → score=255. A further kill keeps score=255.
6. Assert Reset_n=0 for 1 ns mid-G_PLAY with lanes active → all outputs return to reset values before the next Clk edge.
